// File: rtl/enc_bin2onehot_pipe.sv
// Registered binary-to-one-hot encoder with valid/ready on both sides.
// A two-entry buffer (head + skid) sustains one beat per cycle under backpressure
// while keeping in_ready a pure register output.
// Optional macro ENC_ERR_CNT_EN adds an 8-bit saturating out-of-range beat counter (err_cnt).
module enc_bin2onehot_pipe #(
    parameter int unsigned IN_W  = 4,
    parameter int unsigned OUT_N = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_N-1:0] out,
    output logic             out_err,
    output logic             err_sticky,
    input  logic             err_clr
`ifdef ENC_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    // One wider than the index so OUT_N == 2^IN_W is representable; then no index is out of range.
    localparam logic [IN_W:0] OutLimit = (IN_W + 1)'(OUT_N);

    typedef enum logic [1:0] {
        StEmpty,
        StOne,
        StFull
    } state_e;

    state_e           state_q, state_d;
    logic [OUT_N-1:0] head_out_q, head_out_d;
    logic [OUT_N-1:0] skid_out_q, skid_out_d;
    logic             head_err_q, head_err_d;
    logic             skid_err_q, skid_err_d;
    logic             in_ready_q, in_ready_d;
    logic             sticky_q, sticky_d;

    logic [OUT_N-1:0] enc_out;
    logic             enc_err;
    logic             accept;
    logic             pop;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_ready & (state_q != StEmpty);

    // Encode the incoming index; out-of-range values yield an all-zero vector.
    always_comb begin
        enc_out = '0;
        enc_err = ({1'b0, in} >= OutLimit);
        for (int unsigned i = 0; i < OUT_N; i++) begin
            enc_out[i] = ({1'b0, in} == (IN_W + 1)'(i));
        end
    end

    // Buffer occupancy FSM and head/skid data movement.
    always_comb begin
        state_d    = state_q;
        head_out_d = head_out_q;
        head_err_d = head_err_q;
        skid_out_d = skid_out_q;
        skid_err_d = skid_err_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    head_out_d = enc_out;
                    head_err_d = enc_err;
                    state_d    = StOne;
                end
            end
            StOne: begin
                if (accept && pop) begin
                    head_out_d = enc_out;
                    head_err_d = enc_err;
                end else if (accept) begin
                    skid_out_d = enc_out;
                    skid_err_d = enc_err;
                    state_d    = StFull;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // in_ready is low here, so nothing can be accepted.
                if (pop) begin
                    head_out_d = skid_out_q;
                    head_err_d = skid_err_q;
                    state_d    = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        in_ready_d = (state_d != StFull);
    end

    // Sticky error: a new out-of-range acceptance outranks a same-cycle clear.
    always_comb begin
        sticky_d = sticky_q;
        if (accept && enc_err) begin
            sticky_d = 1'b1;
        end else if (err_clr) begin
            sticky_d = 1'b0;
        end
    end

    // State and data registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StEmpty;
            head_out_q <= '0;
            head_err_q <= 1'b0;
            skid_out_q <= '0;
            skid_err_q <= 1'b0;
            in_ready_q <= 1'b1;
            sticky_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_out_q <= head_out_d;
            head_err_q <= head_err_d;
            skid_out_q <= skid_out_d;
            skid_err_q <= skid_err_d;
            in_ready_q <= in_ready_d;
            sticky_q   <= sticky_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != StEmpty);
    assign out        = head_out_q;
    assign out_err    = head_err_q;
    assign err_sticky = sticky_q;

`ifdef ENC_ERR_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Saturating count of out-of-range acceptances; a same-cycle clear restarts it at 1.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && enc_err) begin
            if (err_clr) begin
                cnt_d = 8'd1;
            end else if (cnt_q != 8'hff) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (err_clr) begin
            cnt_d = 8'd0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_enc_bin2onehot_pipe.sv
// Directed bench for enc_bin2onehot_pipe: vector table plus hand-written
// backpressure, sticky-error, reset and parameter-variant sequences.
module tb_enc_bin2onehot_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_s;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_s;
    logic        out_err;
    logic        err_sticky;
    logic        err_clr;
`ifdef ENC_ERR_CNT_EN
    logic [7:0]  err_cnt;
    logic [7:0]  err_cnt2;
`endif

    // Second instance: IN_W=3, OUT_N=8, where every index is in range.
    logic        in_valid2;
    logic        in_ready2;
    logic [2:0]  in2;
    logic        out_valid2;
    logic        out_ready2;
    logic [7:0]  out2;
    logic        out_err2;
    logic        err_sticky2;

    int checks = 0;
    int errors = 0;

    enc_bin2onehot_pipe #(.IN_W(4), .OUT_N(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in         (in_s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out_s),
        .out_err    (out_err),
        .err_sticky (err_sticky),
        .err_clr    (err_clr)
`ifdef ENC_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    enc_bin2onehot_pipe #(.IN_W(3), .OUT_N(8)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid2),
        .in_ready   (in_ready2),
        .in         (in2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready2),
        .out        (out2),
        .out_err    (out_err2),
        .err_sticky (err_sticky2),
        .err_clr    (1'b0)
`ifdef ENC_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  in;
        logic [14:0] exp_out;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Hand-computed table: index -> one-hot / error.
        vecs[0]  = '{4'd0,  15'h0001, 1'b0};
        vecs[1]  = '{4'd1,  15'h0002, 1'b0};
        vecs[2]  = '{4'd2,  15'h0004, 1'b0};
        vecs[3]  = '{4'd3,  15'h0008, 1'b0};
        vecs[4]  = '{4'd4,  15'h0010, 1'b0};
        vecs[5]  = '{4'd5,  15'h0020, 1'b0};
        vecs[6]  = '{4'd6,  15'h0040, 1'b0};
        vecs[7]  = '{4'd7,  15'h0080, 1'b0};
        vecs[8]  = '{4'd8,  15'h0100, 1'b0};
        vecs[9]  = '{4'd9,  15'h0200, 1'b0};
        vecs[10] = '{4'd10, 15'h0400, 1'b0};
        vecs[11] = '{4'd11, 15'h0800, 1'b0};
        vecs[12] = '{4'd12, 15'h1000, 1'b0};
        vecs[13] = '{4'd13, 15'h2000, 1'b0};
        vecs[14] = '{4'd14, 15'h4000, 1'b0};
        vecs[15] = '{4'd15, 15'h0000, 1'b1};

        rst = 1'b0; in_valid = 1'b0; in_s = '0; out_ready = 1'b0; err_clr = 1'b0;
        in_valid2 = 1'b0; in2 = '0; out_ready2 = 1'b0;
        tick(); tick();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out", 32'(out_s), 32'd0);
        chk("reset out_err", 32'(out_err), 32'd0);
        chk("reset err_sticky", 32'(err_sticky), 32'd0);
`ifdef ENC_ERR_CNT_EN
        chk("reset err_cnt", 32'(err_cnt), 32'd0);
`endif
        rst = 1'b1;
        tick();

        // Gating: in toggles without in_valid, nothing may be encoded.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_s = 4'(i);
            tick();
            chk("gated out_valid", 32'(out_valid), 32'd0);
            chk("gated out", 32'(out_s), 32'd0);
        end

        // Basic encode, one-cycle latency.
        in_valid = 1'b1; in_s = 4'd9;
        tick();
        in_valid = 1'b0;
        chk("basic out_valid", 32'(out_valid), 32'd1);
        chk("basic out", 32'(out_s), 32'h0200);
        chk("basic out_err", 32'(out_err), 32'd0);
        tick();
        chk("basic drained", 32'(out_valid), 32'd0);
        chk("no sticky yet", 32'(err_sticky), 32'd0);

        // Table sweep at full throughput; in=15 is last so sticky sets at the end.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_s = vecs[i].in;
            tick();
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d out", i), 32'(out_s), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d out_err", i), 32'(out_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        chk("sticky after oor", 32'(err_sticky), 32'd1);
        tick();
        chk("sweep drained", 32'(out_valid), 32'd0);

        // Clear sticky, then clear coincident with an out-of-range acceptance.
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("sticky cleared", 32'(err_sticky), 32'd0);
        err_clr = 1'b1; in_valid = 1'b1; in_s = 4'd15;
        tick();
        err_clr = 1'b0; in_valid = 1'b0;
        chk("set beats clear", 32'(err_sticky), 32'd1);
        chk("oor out", 32'(out_s), 32'd0);
        chk("oor out_err", 32'(out_err), 32'd1);
`ifdef ENC_ERR_CNT_EN
        chk("cnt set+clr", 32'(err_cnt), 32'd1);
`endif
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("sticky cleared 2", 32'(err_sticky), 32'd0);

        // Backpressure: fill both entries, reject while full, drain in order.
        out_ready = 1'b0;
        in_valid = 1'b1; in_s = 4'd3;
        tick();
        chk("bp1 in_ready", 32'(in_ready), 32'd1);
        chk("bp1 out", 32'(out_s), 32'h0008);
        in_s = 4'd5;
        tick();
        chk("bp2 in_ready", 32'(in_ready), 32'd0);
        chk("bp2 out_valid", 32'(out_valid), 32'd1);
        chk("bp2 out", 32'(out_s), 32'h0008);
        in_s = 4'd7;  // offered while full, must be ignored
        tick(); tick();
        chk("bp hold in_ready", 32'(in_ready), 32'd0);
        chk("bp hold out", 32'(out_s), 32'h0008);
        chk("bp hold out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("drain1 out_valid", 32'(out_valid), 32'd1);
        chk("drain1 out", 32'(out_s), 32'h0020);
        chk("drain1 in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("drain2 out_valid", 32'(out_valid), 32'd0);
        tick();
        chk("drain3 out_valid", 32'(out_valid), 32'd0);

        // Mid-operation reset drops stored beats.
        out_ready = 1'b0; in_valid = 1'b1; in_s = 4'd2;
        tick();
        in_valid = 1'b0;
        chk("pre-reset out_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'd0);
        chk("async reset out", 32'(out_s), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("post-reset out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1; in_valid = 1'b1; in_s = 4'd4;
        tick();
        in_valid = 1'b0;
        chk("post-reset out", 32'(out_s), 32'h0010);
        chk("post-reset valid", 32'(out_valid), 32'd1);
        tick();

        // Narrow instance: all eight indices valid, never an error.
        out_ready2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid2 = 1'b1; in2 = 3'(i);
            tick();
            chk($sformatf("w3 in%0d out", i), 32'(out2), 32'(1) << i);
            chk($sformatf("w3 in%0d out_err", i), 32'(out_err2), 32'd0);
        end
        in_valid2 = 1'b0;
        chk("w3 sticky", 32'(err_sticky2), 32'd0);

`ifdef ENC_ERR_CNT_EN
        // Saturation: 300 out-of-range acceptances, then clear.
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("cnt cleared", 32'(err_cnt), 32'd0);
        out_ready = 1'b1; in_valid = 1'b1; in_s = 4'd15;
        for (int i = 0; i < 300; i++) begin
            tick();
        end
        in_valid = 1'b0;
        chk("cnt saturated", 32'(err_cnt), 32'd255);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("cnt after clr", 32'(err_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/enc_bin2onehot_pipe.md
Name: enc_bin2onehot_pipe

Overview:
Parametrised, registered binary-to-one-hot encoder with a valid/ready stream interface on both sides. It is the next generation of the combinational 4-bit-to-15-output encoder. It adds generic widths, out-of-range detection, a sticky error flag, and a 2-entry skid buffer so it runs at full throughput under backpressure. It sits between decode logic and the per-channel enable fabric.

Parameters:
- IN_W, 4, width of the binary index input (1..8).
- OUT_N, 15, number of one-hot output lines (1..2^IN_W). Index values >= OUT_N are out of range.

Ports:
- clk, input, 1, sole clock, rising edge.
- rst, input, 1, asynchronous active-low reset.
- in_valid, input, 1, upstream beat valid.
- in_ready, output, 1, block can accept a beat.
- in, input, IN_W, binary index.
- out_valid, output, 1, downstream beat valid.
- out_ready, input, 1, downstream accepts the beat.
- out, output, OUT_N, one-hot vector for the head beat.
- out_err, output, 1, head beat was out of range.
- err_sticky, output, 1, set on any accepted out-of-range beat.
- err_clr, input, 1, synchronous clear of err_sticky.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous deassert by the upstream reset synchroniser):
  - both skid entries empty; out_valid=0, in_ready=1, out=0, out_err=0, err_sticky=0.
- Accept condition:
  - A beat is accepted when in_valid=1 and in_ready=1 on a rising clk edge.
  - in is sampled only on acceptance. in_valid=0 beats are never encoded; this is the gated behaviour of the prior block.
- Encode, computed at acceptance and stored:
  - in < OUT_N: out[in]=1, all other bits 0, out_err=0.
  - in >= OUT_N: out=0, out_err=1.
- Latency: out_valid rises on the cycle after acceptance.
- Storage: two entries, head (drives outputs) and skid.
  - in_ready = skid empty. It is a registered function of state only, with no combinational path from out_ready.
- State machine, states EMPTY, ONE, FULL:
  - EMPTY, accept -> ONE.
  - ONE:
    - accept and out_ready -> ONE; head replaced by the new beat.
    - accept and not out_ready -> FULL; new beat goes to skid.
    - out_ready without accept -> EMPTY.
    - neither -> ONE, hold.
  - FULL:
    - in_ready=0.
    - out_ready -> ONE; skid moves to head.
    - otherwise hold.
- Stability: out, out_err and out_valid stay stable while out_valid=1 and out_ready=0.
- Throughput: one beat per cycle whenever out_ready stays high.
- Sticky error:
  - err_sticky is set on the edge where an out-of-range beat is accepted.
  - err_clr=1 clears it on the next edge.
  - Simultaneous set and clear: set wins, so err_sticky=1.
- Width rules:
  - If OUT_N = 2^IN_W, out_err is constant 0.
  - IN_W=1, OUT_N=1: in=0 gives out=1; in=1 is out of range.
- Mid-operation reset: stored beats are dropped and no out_valid appears. The first beat after reset is handled normally.

Optional Feature:
Macro ENC_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt, width 8: a saturating count of accepted out-of-range beats.
  - Reset value 0; holds at 255; cleared to 0 by err_clr.
  - If err_clr and an out-of-range acceptance occur in the same cycle, err_cnt becomes 1.
- Undefined: port err_cnt and its counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset and basic encode: rst low then released; in_valid=1, in=9, out_ready=1 -> next cycle out_valid=1, out=15'h0200, out_err=0.
- Gating: in_valid=0 with in toggling 0..15 -> out_valid stays 0 and out never changes from 0.
- Out of range and sticky: default params, accept in=15 -> out=0, out_err=1, err_sticky=1. Pulse err_clr -> err_sticky=0. err_clr coincident with an in=15 acceptance -> err_sticky stays 1.
- Backpressure: out_ready=0, stream in=3 then 5 -> after 2 accepts in_ready=0, out=15'h0008 held. Raise out_ready -> out=15'h0008, then 15'h0020, in order, no loss or duplication.
- Full throughput: out_ready=1, in=0..14 on consecutive cycles -> 15 consecutive out_valid cycles, out walking 1<<k, in_ready always 1.
- Parameter sweep and feature: IN_W=3, OUT_N=8 (no errors possible, out_err=0 for all 8 inputs). With ENC_ERR_CNT_EN and defaults, 300 accepted in=15 beats -> err_cnt=255, then err_clr -> 0.
